// File: rtl/instr_loader_if.sv
// instr_loader_if: byte-stream receive handshake plus instruction-memory write port
interface instr_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    modport master (output rx_data, rx_valid, input rx_ready, we, waddr, wdata);
    modport slave  (input rx_data, rx_valid, output rx_ready, we, waddr, wdata);
endinterface

// File: rtl/instr_loader.sv
// instr_loader: framed byte-stream loader writing instruction memory and holding the CPU meanwhile
// Define INSTR_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module instr_loader #(
    parameter int ADDR_WIDTH = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    instr_loader_if.slave bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, CHK, DONE, ERR} state_t;
`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam state_t FIN = CHK;
    logic [7:0] csum_q, csum_d;
`else
    localparam state_t FIN = DONE;
`endif
    state_t                state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [23:0]           word_q, word_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
    logic [31:0]           waddr_q, waddr_d, wdata_q, wdata_d;
    logic                  rx_ready_q, rx_ready_d, we_q, we_d, busy_q, busy_d;
    logic                  done_q, done_d, error_q, error_d, acc;
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        acc        = bus.rx_valid && rx_ready_q;
        case (state_q)
            IDLE, DONE, ERR: if (start) begin
                state_d    = HDR0;
                count_d    = '0;
                byte_idx_d = '0;
                word_idx_d = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                csum_d     = '0;
`endif
            end
            HDR0: if (acc) begin
                count_d = {8'h00, bus.rx_data};
                state_d = HDR1;
            end
            HDR1: if (acc) begin
                count_d = {bus.rx_data, count_q[7:0]};
                state_d = count_d > 16'(DEPTH) ? ERR : count_d == 16'd0 ? FIN : DATA;
            end
            DATA: if (acc) begin
                // Bytes shift in from the top so the oldest ends up in [7:0].
                word_d     = {bus.rx_data, word_q[23:8]};
                byte_idx_d = byte_idx_q + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                csum_d     = csum_q ^ bus.rx_data;
`endif
                if (byte_idx_q == 2'd3) begin
                    wdata_d = {bus.rx_data, word_q};
                    waddr_d = 32'({word_idx_q, 2'b00});
                    state_d = WRITE;
                end
            end
            WRITE: begin
                word_idx_d = word_idx_q + ADDR_WIDTH'(1);
                state_d    = 16'(word_idx_q) + 16'd1 == count_q ? FIN : DATA;
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            CHK: if (acc) state_d = bus.rx_data == csum_q ? DONE : ERR;
`endif
            default: ;
        endcase
        rx_ready_d = state_d inside {HDR0, HDR1, DATA, CHK};
        we_d       = state_d == WRITE;
        busy_d     = state_d inside {HDR0, HDR1, DATA, WRITE, CHK};
        done_d     = state_d == DONE;
        error_d    = state_d == ERR;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            word_q     <= '0;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            rx_ready_q <= rx_ready_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end
    assign bus.rx_ready = rx_ready_q;
    assign bus.we       = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign busy         = busy_q;
    assign cpu_hold     = busy_q;
    assign done         = done_q;
    assign error        = error_q;
endmodule
